// File: rtl/ulpb_sleep_ctrl.sv
// Always-on power sequencer for one layer's power-gated bus/layer-controller domain.
// Sequences isolation, clock, reset and power switch in a fixed, timed order.
`ifndef IO_HOLD
`define IO_HOLD 1'b0
`endif
`ifndef IO_RELEASE
`define IO_RELEASE 1'b1
`endif

module ulpb_sleep_ctrl #(
  parameter logic HOLD        = `IO_HOLD,
  parameter logic RELEASE     = `IO_RELEASE,
  parameter int   STEP_CYCLES = 4,
  parameter int   CNT_WIDTH   = 4
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic SLEEP_REQ,
  input  logic WAKEUP_REQ,
  output logic POWER_ON,
  output logic RELEASE_CLK,
  output logic RELEASE_RST,
  output logic RELEASE_ISO,
  output logic SLEEP_STATUS,
  output logic BUSY
);

  typedef enum logic [2:0] {
    SLEEP, UP_PWR, UP_CLK, UP_RST, ACTIVE, DN_ISO, DN_CLK, DN_RST
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(STEP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 wake_pend_q, wake_pend_d;
  logic                 step_done;

  // Control vector {power, clk, rst, iso}; isolation is released last and held first.
  function automatic logic [3:0] ctrl_of(input state_t s);
    case (s)
      SLEEP:   return {HOLD,    HOLD,    HOLD,    HOLD};
      UP_PWR:  return {RELEASE, HOLD,    HOLD,    HOLD};
      UP_CLK:  return {RELEASE, RELEASE, HOLD,    HOLD};
      UP_RST:  return {RELEASE, RELEASE, RELEASE, HOLD};
      ACTIVE:  return {RELEASE, RELEASE, RELEASE, RELEASE};
      DN_ISO:  return {RELEASE, RELEASE, RELEASE, HOLD};
      DN_CLK:  return {RELEASE, HOLD,    RELEASE, HOLD};
      DN_RST:  return {RELEASE, HOLD,    HOLD,    HOLD};
      default: return {HOLD,    HOLD,    HOLD,    HOLD};
    endcase
  endfunction

  function automatic logic is_step(input state_t s);
    return (s != SLEEP) && (s != ACTIVE);
  endfunction

  assign step_done = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    wake_pend_d = wake_pend_q;
    cnt_d       = step_done ? '0 : cnt_q - CNT_WIDTH'(1);
    case (state_q)
      SLEEP: begin
        if (WAKEUP_REQ || wake_pend_q) begin
          state_d     = UP_PWR;
          wake_pend_d = 1'b0;
        end
      end
      UP_PWR: if (step_done) state_d = UP_CLK;
      UP_CLK: if (step_done) state_d = UP_RST;
      UP_RST: if (step_done) state_d = ACTIVE;
      ACTIVE: if (SLEEP_REQ && !WAKEUP_REQ) state_d = DN_ISO;
      // A wake request never aborts power-down; it is remembered and served from SLEEP.
      DN_ISO: begin
        wake_pend_d = wake_pend_q | WAKEUP_REQ;
        if (step_done) state_d = DN_CLK;
      end
      DN_CLK: begin
        wake_pend_d = wake_pend_q | WAKEUP_REQ;
        if (step_done) state_d = DN_RST;
      end
      DN_RST: begin
        wake_pend_d = wake_pend_q | WAKEUP_REQ;
        if (step_done) state_d = SLEEP;
      end
      default: state_d = SLEEP;
    endcase
    if ((state_d != state_q) && is_step(state_d)) cnt_d = CNT_LOAD;
  end

  // State register; outputs are registered decodes of the next state so they stay glitch-free.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= SLEEP;
      cnt_q        <= '0;
      wake_pend_q  <= 1'b0;
      POWER_ON     <= HOLD;
      RELEASE_CLK  <= HOLD;
      RELEASE_RST  <= HOLD;
      RELEASE_ISO  <= HOLD;
      SLEEP_STATUS <= 1'b1;
      BUSY         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wake_pend_q  <= wake_pend_d;
      {POWER_ON, RELEASE_CLK, RELEASE_RST, RELEASE_ISO} <= ctrl_of(state_d);
      SLEEP_STATUS <= (state_d == SLEEP);
      BUSY         <= is_step(state_d);
    end
  end

endmodule
